branch_stack: RTL and testbench

- Tracks every in-flight conditional branch, from dispatch until branch_fu resolves it.
- Allocates one-hot branch IDs and holds a rename checkpoint per branch.
- Consumes branch_fu's br_task / resolution and drives the registered rem_br_task / rem_b_id broadcast that all FUs, RS and ROB use to clear or squash.
- On a mispredict, returns the checkpoint to the rename stage.

---
 rtl/branch_stack.sv | 126 ++++++++++++
 tb/tb_branch_stack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_stack.sv
// Branch stack: one-hot branch ID allocation, per-branch rename checkpoints,
// and the registered clear/squash broadcast driven from branch_fu results.
package branch_stack_pkg;
  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_t;
endpackage

module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [CKPT_W-1:0] alloc_ckpt,
  output logic              alloc_gnt,
  output logic [DEPTH-1:0]  alloc_b_id,
  output logic [DEPTH-1:0]  cur_b_mask,
  output logic              full,
  input  logic              res_valid,
  input  br_task_t          res_task,
  input  logic [DEPTH-1:0]  res_b_id,
  output br_task_t          rem_br_task,
  output logic [DEPTH-1:0]  rem_b_id,
  output logic              restore_valid,
  output logic [CKPT_W-1:0] restore_ckpt
);

  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][DEPTH-1:0]   dep_q, dep_d;
  logic [DEPTH-1:0][CKPT_W-1:0]  ckpt_q;
  logic                          full_q;

  logic              res_onehot;
  logic              res_eff;
  logic              clr_eff;
  logic              sq_eff;
  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  low_free;
  logic [CKPT_W-1:0] sq_ckpt;

  // A resolution only counts when it names exactly one live branch.
  assign res_onehot = (res_b_id != '0) && ((res_b_id & (res_b_id - ONE)) == '0);
  assign res_eff    = res_valid && res_onehot && ((res_b_id & valid_q) != '0);
  assign clr_eff    = res_eff && (res_task == CLEAR);
  assign sq_eff     = res_eff && (res_task == SQUASH);

  assign free_vec = ~valid_q;
  assign low_free = free_vec & (~free_vec + ONE);

  // Room is judged on registered state only; same-cycle frees do not count.
  assign full       = full_q;
  assign alloc_gnt  = alloc_en && !full_q && !sq_eff;
  assign alloc_b_id = alloc_gnt ? low_free : '0;
  assign cur_b_mask = valid_q & ~(clr_eff ? res_b_id : '0);

  always_comb begin
    sq_ckpt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (res_b_id[i]) sq_ckpt = sq_ckpt | ckpt_q[i];
    end
  end

  always_comb begin
    valid_d = valid_q;
    dep_d   = dep_q;
    if (clr_eff) begin
      valid_d = valid_d & ~res_b_id;
      for (int i = 0; i < DEPTH; i++) dep_d[i] = dep_q[i] & ~res_b_id;
    end
    if (sq_eff) begin
      valid_d = valid_d & ~res_b_id;
      // Anything that depends on the squashed branch dies with it.
      for (int i = 0; i < DEPTH; i++) begin
        if ((dep_q[i] & res_b_id) != '0) begin
          valid_d[i] = 1'b0;
          dep_d[i]   = '0;
        end
      end
    end
    if (alloc_gnt) begin
      valid_d = valid_d | alloc_b_id;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_b_id[i]) dep_d[i] = cur_b_mask;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dep_q   <= '0;
      ckpt_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dep_q   <= dep_d;
      full_q  <= &valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_b_id[i]) ckpt_q[i] <= alloc_ckpt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_br_task   <= NOTHING;
      rem_b_id      <= '0;
      restore_valid <= 1'b0;
      restore_ckpt  <= '0;
    end else begin
      rem_br_task   <= clr_eff ? CLEAR : (sq_eff ? SQUASH : NOTHING);
      rem_b_id      <= res_eff ? res_b_id : '0;
      restore_valid <= sq_eff;
      restore_ckpt  <= sq_eff ? sq_ckpt : '0;
    end
  end

endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_branch_stack;
  import branch_stack_pkg::*;

  localparam int D  = 4;
  localparam int CW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_en = 1'b0;
  logic [CW-1:0] alloc_ckpt = '0;
  logic          alloc_gnt;
  logic [D-1:0]  alloc_b_id;
  logic [D-1:0]  cur_b_mask;
  logic          full;
  logic          res_valid = 1'b0;
  br_task_t      res_task = NOTHING;
  logic [D-1:0]  res_b_id = '0;
  br_task_t      rem_br_task;
  logic [D-1:0]  rem_b_id;
  logic          restore_valid;
  logic [CW-1:0] restore_ckpt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_stack #(.DEPTH(D), .CKPT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .alloc_en(alloc_en), .alloc_ckpt(alloc_ckpt),
    .alloc_gnt(alloc_gnt), .alloc_b_id(alloc_b_id),
    .cur_b_mask(cur_b_mask), .full(full),
    .res_valid(res_valid), .res_task(res_task), .res_b_id(res_b_id),
    .rem_br_task(rem_br_task), .rem_b_id(rem_b_id),
    .restore_valid(restore_valid), .restore_ckpt(restore_ckpt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-entry arrays, updated once per clock.
  bit          mv [D];
  bit [D-1:0]  mdep [D];
  bit [CW-1:0] mck [D];
  br_task_t    mtask;
  bit [D-1:0]  mrid;
  bit          mrv;
  bit [CW-1:0] mrc;

  bit          nv [D];
  bit [D-1:0]  ndep [D];
  bit [CW-1:0] nck [D];
  br_task_t    ntask;
  bit [D-1:0]  nrid;
  bit          nrv;
  bit [CW-1:0] nrc;

  bit          e_full, e_eff, e_clr, e_sq, e_gnt;
  int          e_bi, e_gi;
  bit [D-1:0]  e_mask, e_id;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 0; mdep[i] = '0; mck[i] = '0;
      nv[i] = 0; ndep[i] = '0; nck[i] = '0;
    end
    mtask = NOTHING; mrid = '0; mrv = 0; mrc = '0;
    ntask = NOTHING; nrid = '0; nrv = 0; nrc = '0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else begin
      for (int i = 0; i < D; i++) begin
        mv[i] = nv[i]; mdep[i] = ndep[i]; mck[i] = nck[i];
      end
      mtask = ntask; mrid = nrid; mrv = nrv; mrc = nrc;
    end
  end

  // Compare process: check every cycle out of reset, then compute next model state.
  always @(negedge clock) begin
    if (reset) begin
      e_full = 1;
      for (int i = 0; i < D; i++) if (!mv[i]) e_full = 0;
      e_bi = 0;
      for (int i = 0; i < D; i++) if (res_b_id[i]) e_bi = i;
      e_eff = res_valid && ($countones(res_b_id) == 1) && mv[e_bi];
      e_clr = e_eff && (res_task == CLEAR);
      e_sq  = e_eff && (res_task == SQUASH);
      e_mask = '0;
      for (int i = 0; i < D; i++) if (mv[i] && !(e_clr && i == e_bi)) e_mask[i] = 1'b1;
      e_gi = -1;
      for (int i = D - 1; i >= 0; i--) if (!mv[i]) e_gi = i;
      e_gnt = alloc_en && !e_full && !e_sq && (e_gi >= 0);
      e_id  = e_gnt ? D'(1 << e_gi) : '0;

      chk("alloc_gnt", 64'(alloc_gnt), 64'(e_gnt));
      chk("alloc_b_id", 64'(alloc_b_id), 64'(e_id));
      chk("cur_b_mask", 64'(cur_b_mask), 64'(e_mask));
      chk("full", 64'(full), 64'(e_full));
      chk("rem_br_task", 64'(rem_br_task), 64'(mtask));
      chk("rem_b_id", 64'(rem_b_id), 64'(mrid));
      chk("restore_valid", 64'(restore_valid), 64'(mrv));
      if (mrv) chk("restore_ckpt", restore_ckpt, mrc);

      for (int i = 0; i < D; i++) begin
        nv[i] = mv[i]; ndep[i] = mdep[i]; nck[i] = mck[i];
      end
      if (e_clr) begin
        nv[e_bi] = 0;
        for (int i = 0; i < D; i++) ndep[i][e_bi] = 1'b0;
      end
      if (e_sq) begin
        nv[e_bi] = 0;
        for (int j = 0; j < D; j++)
          if (mdep[j][e_bi]) begin nv[j] = 0; ndep[j] = '0; end
      end
      if (e_gnt) begin
        nv[e_gi] = 1; ndep[e_gi] = e_mask; nck[e_gi] = alloc_ckpt;
      end
      ntask = e_clr ? CLEAR : (e_sq ? SQUASH : NOTHING);
      nrid  = e_eff ? res_b_id : '0;
      nrv   = e_sq;
      nrc   = e_sq ? mck[e_bi] : '0;
    end
  end

  task automatic drive(input bit ae, input logic [CW-1:0] ck, input bit rv,
                       input br_task_t rt, input logic [D-1:0] rid);
    alloc_en = ae; alloc_ckpt = ck; res_valid = rv; res_task = rt; res_b_id = rid;
  endtask

  task automatic idle();
    drive(0, '0, 0, NOTHING, '0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic alloc_one(input logic [CW-1:0] ck);
    drive(1, ck, 0, NOTHING, '0);
    tick();
  endtask

  initial begin
    #1;
    chk("reset rem_br_task", 64'(rem_br_task), 64'(NOTHING));
    chk("reset restore_valid", 64'(restore_valid), 64'd0);
    chk("reset full", 64'(full), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Fill
    for (int k = 0; k < 5; k++) begin
      drive(1, CW'(k + 1), 0, NOTHING, '0);
      @(negedge clock);
      chk("fill alloc_b_id", 64'(alloc_b_id), (k < 4) ? 64'(1 << k) : 64'd0);
      chk("fill full", 64'(full), (k == 4) ? 64'd1 : 64'd0);
      tick();
    end

    // Clear oldest
    do_reset();
    alloc_one(64'hA);
    alloc_one(64'hB);
    drive(0, '0, 1, CLEAR, 4'b0001);
    @(negedge clock);
    chk("clr same-cycle mask", 64'(cur_b_mask), 64'b0010);
    tick();
    idle();
    @(negedge clock);
    chk("clr rem_br_task", 64'(rem_br_task), 64'(CLEAR));
    chk("clr rem_b_id", 64'(rem_b_id), 64'b0001);
    chk("clr restore_valid", 64'(restore_valid), 64'd0);
    chk("clr cur_b_mask", 64'(cur_b_mask), 64'b0010);
    tick();

    // Squash with younger branches
    do_reset();
    alloc_one(64'hA);
    alloc_one(64'hB);
    alloc_one(64'hC);
    drive(0, '0, 1, SQUASH, 4'b0010);
    tick();
    drive(1, 64'hD, 0, NOTHING, '0);
    @(negedge clock);
    chk("sq rem_br_task", 64'(rem_br_task), 64'(SQUASH));
    chk("sq rem_b_id", 64'(rem_b_id), 64'b0010);
    chk("sq restore_valid", 64'(restore_valid), 64'd1);
    chk("sq restore_ckpt", restore_ckpt, 64'hB);
    chk("sq cur_b_mask", 64'(cur_b_mask), 64'b0001);
    chk("sq next alloc", 64'(alloc_b_id), 64'b0010);
    tick();
    idle();
    @(negedge clock);
    chk("sq restore one cycle", 64'(restore_valid), 64'd0);
    tick();

    // Simultaneous CLEAR + alloc on a full stack
    do_reset();
    for (int k = 0; k < 4; k++) alloc_one(CW'(k));
    drive(1, 64'h55, 1, CLEAR, 4'b0001);
    @(negedge clock);
    chk("full clr alloc_gnt", 64'(alloc_gnt), 64'd0);
    tick();
    drive(1, 64'h66, 0, NOTHING, '0);
    @(negedge clock);
    chk("after clr alloc_gnt", 64'(alloc_gnt), 64'd1);
    chk("after clr alloc_b_id", 64'(alloc_b_id), 64'b0001);
    chk("after clr dep mask", 64'(cur_b_mask), 64'b1110);
    tick();

    // SQUASH + alloc with free entries
    do_reset();
    alloc_one(64'h1);
    alloc_one(64'h2);
    drive(1, 64'h3, 1, SQUASH, 4'b0001);
    @(negedge clock);
    chk("sq+alloc alloc_gnt", 64'(alloc_gnt), 64'd0);
    tick();

    // Invalid resolutions
    do_reset();
    alloc_one(64'h1);
    alloc_one(64'h2);
    drive(0, '0, 1, CLEAR, 4'b0100);
    tick();
    drive(0, '0, 1, SQUASH, 4'b0110);
    @(negedge clock);
    chk("inv free rem_br_task", 64'(rem_br_task), 64'(NOTHING));
    chk("inv free mask", 64'(cur_b_mask), 64'b0011);
    tick();
    idle();
    @(negedge clock);
    chk("inv multi rem_br_task", 64'(rem_br_task), 64'(NOTHING));
    chk("inv multi rem_b_id", 64'(rem_b_id), 64'd0);
    chk("inv multi mask", 64'(cur_b_mask), 64'b0011);
    tick();

    // Async reset mid-cycle with a pending broadcast
    do_reset();
    alloc_one(64'h1);
    alloc_one(64'h2);
    alloc_one(64'h3);
    drive(0, '0, 1, SQUASH, 4'b0100);
    tick();
    idle();
    #1 reset = 1'b0;
    #1;
    chk("async rem_br_task", 64'(rem_br_task), 64'(NOTHING));
    chk("async restore_valid", 64'(restore_valid), 64'd0);
    chk("async cur_b_mask", 64'(cur_b_mask), 64'd0);
    chk("async full", 64'(full), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      automatic int r = $urandom_range(0, 9);
      automatic logic [D-1:0] rid;
      automatic br_task_t rt;
      rid = (r < 7) ? D'(1 << $urandom_range(0, D - 1)) : D'($urandom);
      r = $urandom_range(0, 9);
      rt = (r < 5) ? CLEAR : ((r < 8) ? SQUASH : NOTHING);
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 2) != 0, rt, rid);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
